// File: rtl/spi_master.sv
// SPI mode-0 master. Loads a parallel word on start, shifts it out MSB first on
// mosi while capturing miso, then returns the received word with a done pulse.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);
    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_master: CLK_DIV must be >= 1");
    end

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT_HI, SHIFT_LO, TRAIL} state_t;

    state_t                state;
    logic [CW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  half_end;

    assign half_end = (div_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state != IDLE)
                div_cnt <= half_end ? '0 : div_cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_shift <= tx_data;
                        rx_shift <= '0;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        mosi     <= tx_data[DATA_WIDTH-1];
                        sclk     <= 1'b0;
                        div_cnt  <= '0;
                        state    <= LEAD;
                    end
                end
                LEAD: begin
                    if (half_end) begin
                        sclk    <= 1'b1;
                        bit_cnt <= BW'(DATA_WIDTH - 1);
                        state   <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    // miso is sampled on the same edge that drops sclk, before the
                    // slave moves to its next bit.
                    if (half_end) begin
                        sclk              <= 1'b0;
                        rx_shift[bit_cnt] <= miso;
                        mosi              <= (bit_cnt == '0) ? 1'b0 : tx_shift[bit_cnt - BW'(1)];
                        state             <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (half_end) begin
                        if (bit_cnt == '0) begin
                            state <= TRAIL;
                        end else begin
                            sclk    <= 1'b1;
                            bit_cnt <= bit_cnt - BW'(1);
                            state   <= SHIFT_HI;
                        end
                    end
                end
                TRAIL: begin
                    if (half_end) begin
                        cs_n    <= 1'b1;
                        busy    <= 1'b0;
                        mosi    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_shift;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural slave/loopback on miso, per-cycle observation
// of the SPI pins and a word-level reference model of each transfer.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A: default CLK_DIV=2
    logic       a_start, a_busy, a_done, a_sclk, a_mosi, a_miso, a_cs_n;
    logic [7:0] a_tx, a_rx;
    // instance B: CLK_DIV=1, miso looped to mosi
    logic       b_start, b_busy, b_done, b_sclk, b_mosi, b_cs_n;
    logic [7:0] b_tx, b_rx;

    int total = 0;
    int bad   = 0;

    spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx), .rx_data(a_rx),
        .busy(a_busy), .done(a_done), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso), .cs_n(a_cs_n));

    spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx), .rx_data(b_rx),
        .busy(b_busy), .done(b_done), .sclk(b_sclk), .mosi(b_mosi), .miso(b_mosi), .cs_n(b_cs_n));

    // behavioural mode-0 slave: presents MSB when selected, next bit on each sclk fall
    logic [7:0] reply_word = 8'h00;
    logic [7:0] reply_sh   = 8'h00;
    bit         loop       = 1'b0;
    always @(negedge a_cs_n) reply_sh = reply_word;
    always @(negedge a_sclk) reply_sh = {reply_sh[6:0], 1'b0};
    assign a_miso = loop ? a_mosi : reply_sh[7];

    // Runs one transfer on instance A and reports what was seen on the pins.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] reply, input bit lp,
                        input int mid_start, output logic [7:0] mosi_w, output logic [7:0] rx,
                        output int busy_n, output int cs_low, output int done_n,
                        output int rises, output bit runs_ok);
        int   runs[$];
        int   cur, after_done;
        logic prev;
        reply_word = reply; loop = lp;
        mosi_w = 8'h00; rx = 8'hxx; busy_n = 0; cs_low = 0; done_n = 0; rises = 0;
        cur = 0; prev = 1'b0; after_done = -1;
        @(negedge clk); a_tx = tx; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; a_tx = 8'($urandom);
        for (int cyc = 0; cyc < 120 && after_done < 3; cyc++) begin
            if (a_busy) busy_n++;
            if (!a_cs_n) begin
                cs_low++;
                if (a_sclk && !prev) begin
                    rises++;
                    mosi_w = {mosi_w[6:0], a_mosi};
                end
                if (cur == 0 || a_sclk == prev) cur++;
                else begin runs.push_back(cur); cur = 1; end
                prev = a_sclk;
            end else if (cur > 0) begin
                runs.push_back(cur); cur = 0;
            end
            if (a_done) begin done_n++; rx = a_rx; end
            if (after_done >= 0 || a_done) after_done++;
            if (cyc == mid_start) begin a_start = 1'b1; a_tx = 8'h55; end
            else a_start = 1'b0;
            @(negedge clk);
        end
        // expected sclk run lengths while selected: lead low, 8 highs, 7 lows,
        // then last low phase merged with the trail
        runs_ok = (runs.size() == 17);
        for (int i = 0; i < runs.size() && i < 17; i++)
            if (runs[i] != ((i == 16) ? 4 : 2)) runs_ok = 1'b0;
    endtask

    task automatic check_xfer(input string name, input logic [7:0] tx, input logic [7:0] reply,
                              input bit lp, input int mid_start);
        logic [7:0] mw, rx, exp_rx;
        int bn, cl, dn, rs;
        bit ro;
        xfer(tx, reply, lp, mid_start, mw, rx, bn, cl, dn, rs, ro);
        exp_rx = lp ? tx : reply;
        total++; if (rx !== exp_rx) begin bad++; $display("FAIL %s rx got=%h exp=%h", name, rx, exp_rx); end
        total++; if (mw !== tx) begin bad++; $display("FAIL %s mosi_bits got=%h exp=%h", name, mw, tx); end
        total++; if (dn !== 1) begin bad++; $display("FAIL %s done_count got=%0d exp=1", name, dn); end
        total++; if (bn !== 36) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=36", name, bn); end
        total++; if (cl !== 36) begin bad++; $display("FAIL %s cs_low_cycles got=%0d exp=36", name, cl); end
        total++; if (rs !== 8) begin bad++; $display("FAIL %s sclk_rises got=%0d exp=8", name, rs); end
        total++; if (ro !== 1'b1) begin bad++; $display("FAIL %s sclk_phases got=%0d exp=1", name, ro); end
    endtask

    task automatic check_idle(input string name, input logic [7:0] exp_rx);
        total++;
        if ({a_sclk, a_mosi, a_cs_n, a_busy, a_done, a_rx} !== {4'b0010, 1'b0, exp_rx}) begin
            bad++;
            $display("FAIL %s got sclk=%b mosi=%b cs_n=%b busy=%b done=%b rx=%h exp 0 0 1 0 0 %h",
                     name, a_sclk, a_mosi, a_cs_n, a_busy, a_done, a_rx, exp_rx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_tx = 8'h00; b_tx = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset_state", 8'h00);
        a_start = 1'b1; a_tx = 8'hFF;
        @(negedge clk);
        check_idle("rst_beats_start", 8'h00);
        rst = 1'b0; a_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        check_xfer("loop_cc", 8'hCC, 8'h00, 1'b1, -1);
    endtask

    task automatic test_slave_reply();
        check_xfer("slave_aa_cc", 8'hCC, 8'hAA, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            check_xfer("random", 8'($urandom), 8'($urandom), 1'($urandom), -1);
    endtask

    task automatic test_ignore_start();
        check_xfer("restart_ignored", 8'h96, 8'h3E, 1'b0, 10);
    endtask

    task automatic test_reset_mid();
        int dn, csh;
        reply_word = 8'h81; loop = 1'b0;
        @(negedge clk); a_tx = 8'h7E; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_mid", 8'h00);
        dn = 0; csh = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_done) dn++;
            if (a_cs_n) csh++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL reset_mid_no_done got=%0d exp=0", dn); end
        total++; if (csh !== 40) begin bad++; $display("FAIL reset_mid_cs_idle got=%0d exp=40", csh); end
        check_xfer("after_reset", 8'h5A, 8'hC3, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        int runs[$];
        logic [7:0] words[$];
        int cur, dn, gap_n, tail;
        bit gap;
        cur = 0; dn = 0; gap_n = 0; gap = 1'b0; tail = -1;
        @(negedge clk); b_tx = 8'hA5; b_start = 1'b1;
        @(negedge clk); b_tx = 8'h3C;
        for (int cyc = 0; cyc < 100 && tail < 3; cyc++) begin
            if (b_busy) cur++;
            else if (cur > 0) begin runs.push_back(cur); cur = 0; end
            if (b_done) begin dn++; words.push_back(b_rx); gap = (dn == 1); end
            if (gap && b_cs_n) gap_n++;
            if (!b_cs_n) gap = 1'b0;
            if (dn == 1 && b_busy) b_start = 1'b0;
            if (dn >= 2) tail++;
            @(negedge clk);
        end
        b_start = 1'b0;
        total++; if (dn !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dn); end
        total++; if (gap_n !== 1) begin bad++; $display("FAIL b2b_cs_gap got=%0d exp=1", gap_n); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (runs.size() <= i || runs[i] !== 18) begin
                bad++; $display("FAIL b2b_busy_len[%0d] got=%0d exp=18", i, (runs.size() > i) ? runs[i] : -1);
            end
        end
        total++; if (words.size() < 1 || words[0] !== 8'hA5) begin bad++; $display("FAIL b2b_word0 got=%h exp=a5", (words.size() > 0) ? words[0] : 8'hxx); end
        total++; if (words.size() < 2 || words[1] !== 8'h3C) begin bad++; $display("FAIL b2b_word1 got=%h exp=3c", (words.size() > 1) ? words[1] : 8'hxx); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave_reply();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
